// File: rtl/prbs_frame_ctrl.sv
// rtl/prbs_frame_ctrl.sv - frame sequencer owning the 15-bit PRBS scrambler load/en/seed controls
`timescale 1ns/1ps
module prbs_frame_ctrl #(
  parameter int FRAME_LEN = 96,
  parameter int SEED_W    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              abort,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              prbs_load,
  output logic              prbs_en,
  output logic [SEED_W-1:0] prbs_seed,
  output logic              prbs_data_in,
  input  logic              prbs_data_out,
  output logic              out_valid,
  output logic              out_bit,
  output logic              busy,
  output logic              done,
  output logic              seed_err,
  output logic [6:0]        bit_cnt,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [6:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              seed_err_q, seed_err_d;
  logic              start_ok, start_bad, xfer;

  assign start_ok  = (state_q == S_IDLE) && start && (seed_in != '0);
  assign start_bad = (state_q == S_IDLE) && start && (seed_in == '0);
  // abort wins over the handshake: the scrambler must not advance in an aborted cycle
  assign xfer      = (state_q == S_RUN) && in_valid && !abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer && (bit_cnt_q == LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_RUN) && !abort;
    prbs_load = (state_q == S_LOAD);
    prbs_en   = xfer;
    out_valid = xfer;
    out_bit   = xfer & prbs_data_out;
    busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    done      = (state_q == S_DONE);
  end

  always_comb begin
    seed_d      = seed_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    seed_err_d  = start_bad;
    if (start_ok) begin
      seed_d    = seed_in;
      bit_cnt_d = '0;
    end
    if (xfer) begin
      bit_cnt_d = bit_cnt_q + 7'd1;
    end
    if (state_q == S_DONE) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seed_q      <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      seed_err_q  <= 1'b0;
    end else begin
      seed_q      <= seed_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      seed_err_q  <= seed_err_d;
    end
  end

  assign prbs_seed    = seed_q;
  assign prbs_data_in = in_bit;
  assign bit_cnt      = bit_cnt_q;
  assign frame_cnt    = frame_cnt_q;
  assign seed_err     = seed_err_q;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// tb/tb_prbs_frame_ctrl.sv - randomized self-checking bench for prbs_frame_ctrl
`timescale 1ns/1ps
module tb_prbs_frame_ctrl;

  localparam int FL = 96;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [14:0] seed_in = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_ready, prbs_load, prbs_en, prbs_data_in, prbs_data_out;
  logic [14:0] prbs_seed;
  logic        out_valid, out_bit, busy, done, seed_err;
  logic [6:0]  bit_cnt;
  logic [7:0]  frame_cnt;

  logic [14:0] scr_q = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          fc_model = 0;
  int          last_done = -100;
  bit          keys[FL];

  prbs_frame_ctrl #(.FRAME_LEN(FL), .SEED_W(15)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in), .abort(abort),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .prbs_load(prbs_load), .prbs_en(prbs_en), .prbs_seed(prbs_seed),
    .prbs_data_in(prbs_data_in), .prbs_data_out(prbs_data_out),
    .out_valid(out_valid), .out_bit(out_bit), .busy(busy), .done(done),
    .seed_err(seed_err), .bit_cnt(bit_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scrambler instance stand-in: x^15 + x^14 + 1, output tap on the MSB
  always @(posedge clk) begin
    if (prbs_load) scr_q <= prbs_seed;
    else if (prbs_en) scr_q <= {scr_q[13:0], scr_q[14] ^ scr_q[13]};
  end
  assign prbs_data_out = prbs_data_in ^ scr_q[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic make_keys(input logic [14:0] seed);
    logic [14:0] s;
    s = seed;
    for (int k = 0; k < FL; k++) begin
      keys[k] = s[14];
      s = {s[13:0], s[14] ^ s[13]};
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_load"}, prbs_load, 0);
    check({tag, "_en"}, prbs_en, 0);
    check({tag, "_seed"}, prbs_seed, 0);
    check({tag, "_oval"}, out_valid, 0);
    check({tag, "_obit"}, out_bit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_seed_err"}, seed_err, 0);
    check({tag, "_bit_cnt"}, bit_cnt, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // mode: 0 continuous valid, 1 valid pattern 1,0,0,1, 2 random valid
  task automatic run_frame(input logic [14:0] seed, input int mode, input int abort_at,
                           input int rst_at, input bit noise, input bit chk_gap);
    int n, k, load_cyc, first_xfer;
    bit v, b, ab, rs, xf;
    make_keys(seed);
    start = 1'b1;
    seed_in = seed;
    @(posedge clk); #1;
    start = 1'b0;
    seed_in = 15'($urandom);
    load_cyc = cyc;
    check("load", prbs_load, 1);
    check("busy_load", busy, 1);
    check("en_load", prbs_en, 0);
    check("ready_load", in_ready, 0);
    check("bit_cnt_clr", bit_cnt, 0);
    check("seed_latch", prbs_seed, seed);
    @(posedge clk); #1;
    n = 0;
    k = 0;
    first_xfer = -1;
    while (n < FL) begin
      case (mode)
        0: v = 1'b1;
        1: v = (k % 4 == 0) || (k % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      b  = 1'($urandom_range(0, 1));
      ab = (n == abort_at) && v;
      rs = (n == rst_at);
      in_valid = v;
      in_bit = b;
      abort = ab;
      reset = ~rs;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        seed_in = 15'($urandom);
      end
      @(negedge clk);
      xf = v && !ab;
      check("ready", in_ready, !ab);
      check("en", prbs_en, xf);
      check("out_valid", out_valid, xf);
      check("load_run", prbs_load, 0);
      check("busy_run", busy, 1);
      check("bit_cnt", bit_cnt, n);
      check("done_early", done, 0);
      check("seed_hold", prbs_seed, seed);
      check("data_in", prbs_data_in, b);
      if (xf) check("out_bit", out_bit, b ^ keys[n]);
      if (xf && first_xfer < 0) first_xfer = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b1;
      in_valid = 1'b0;
      if (rs) begin
        check_all_zero("rst_mid");
        fc_model = 0;
        last_done = -100;
        return;
      end
      if (ab) begin
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bit_cnt", bit_cnt, n);
        check("abort_frame_cnt", frame_cnt, fc_model);
        last_done = -100;
        return;
      end
      if (xf) n++;
      k++;
      if (k > 1000) begin
        check("frame_timeout", 0, 1);
        return;
      end
    end
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("ready_done", in_ready, 0);
    check("bit_cnt_done", bit_cnt, FL);
    if (mode == 0) check("done_latency", cyc - load_cyc, FL + 1);
    if (chk_gap) check("gap", first_xfer - last_done, 3);
    last_done = cyc;
    fc_model = (fc_model + 1) % 256;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("frame_cnt", frame_cnt, fc_model);
    check("busy_idle", busy, 0);
    check("bit_cnt_hold", bit_cnt, FL);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    start = 1'b1;
    seed_in = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("seed_err", seed_err, 1);
    check("zero_seed_busy", busy, 0);
    check("zero_seed_load", prbs_load, 0);
    @(posedge clk); #1;
    check("seed_err_pulse", seed_err, 0);
    check("zero_seed_busy2", busy, 0);

    run_frame(15'h2AAA, 0, -1, -1, 1'b0, 1'b0);
    run_frame(15'h2AAA, 1, -1, -1, 1'b0, 1'b0);
    run_frame(15'h2AAA, 0, 40, -1, 1'b0, 1'b0);
    run_frame(15'h2AAA, 0, -1, -1, 1'b0, 1'b0);
    run_frame(15'($urandom_range(1, 32767)), 2, -1, -1, 1'b1, 1'b0);
    run_frame(15'($urandom_range(1, 32767)), 2, -1, 70, 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) begin
      run_frame(15'($urandom_range(1, 32767)), 0, -1, -1, 1'b0, i > 0);
    end
    check("wrap", frame_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_frame_ctrl.md
# prbs_frame_ctrl

Frame sequencer for the 15-bit PRBS scrambler datapath. It accepts a start request with a seed, issues a one-cycle seed load, then streams exactly FRAME_LEN input bits through the scrambler under a valid/ready handshake. It forwards scrambled bits downstream, pulses done at frame end, and counts completed frames. It sits between the serial data source and the scrambler instance, and owns the scrambler's load/en/seed controls.

## Interface
- FRAME_LEN, 96: bits per frame; legal range 2..127
- SEED_W, 15: scrambler seed width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- seed_in  in  SEED_W  seed for the requested frame; sampled with start
- abort  in  1  terminate current frame
- in_valid  in  1  serial source has a bit
- in_bit  in  1  serial source data
- in_ready  out  1  controller accepts in_bit this cycle
- prbs_load  out  1  scrambler seed load strobe
- prbs_en  out  1  scrambler advance enable
- prbs_seed  out  SEED_W  latched seed to scrambler
- prbs_data_in  out  1  bit to scrambler (= in_bit)
- prbs_data_out  in  1  scrambled bit from scrambler (combinational from data_in and current state)
- out_valid  out  1  out_bit valid
- out_bit  out  1  scrambled bit
- busy  out  1  frame in progress (LOAD or RUN)
- done  out  1  one-cycle frame-complete pulse
- seed_err  out  1  one-cycle pulse: start rejected because seed_in == 0
- bit_cnt  out  7  bits accepted in current frame
- frame_cnt  out  8  completed frames, wraps 255 -> 0

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 and seed_in!=0: latch seed_in into prbs_seed, clear bit_cnt, go to LOAD.
  - start=1 and seed_in==0: seed_err=1 for one cycle, stay in IDLE.
- LOAD: prbs_load=1 for exactly one cycle, then RUN. abort in LOAD goes to IDLE; the load strobe still fires.
- RUN:
  - in_ready = ~abort. Transfer = in_valid & in_ready.
  - On a transfer: prbs_en=1, out_valid=1, out_bit=prbs_data_out, bit_cnt+1.
  - No transfer: prbs_en=0, out_valid=0, and scrambler state is held (stall of any length is legal).
  - Transfer with bit_cnt==FRAME_LEN-1: go to DONE; bit_cnt reads FRAME_LEN there.
  - abort=1: no transfer that cycle, go to IDLE; done is not pulsed and frame_cnt is unchanged.
- DONE: done=1 for one cycle, frame_cnt+1 (modulo 256), go to IDLE. bit_cnt holds until the next accepted start.
- start outside IDLE is ignored; start is not queued.
- busy = (state==LOAD or RUN).
- prbs_data_in = in_bit at all times. Only prbs_en qualifies it.
- prbs_load and prbs_en are never high in the same cycle.

## Timing
- Reset (reset=0 at a clk edge) forces IDLE from any state. All outputs become 0: prbs_seed, bit_cnt and frame_cnt clear; load, en, valid, done, seed_err and busy are 0.
- A mid-frame reset discards the frame and does not pulse done.
- start accepted at edge N: prbs_load high in cycle N+1; in_ready first high in cycle N+2.
- Minimum frame duration, start to done: FRAME_LEN+2 cycles with continuous in_valid. done is high in cycle N+2+FRAME_LEN.
- Back-to-back frames: start may be accepted in the cycle after done. IDLE lasts at least 1 cycle, so the minimum frame period is FRAME_LEN+3.
- out_valid/out_bit are combinational in the transfer cycle. Zero latency from in_bit to out_bit, with one LFSR step per transfer.
- seed_err and done are registered single-cycle pulses.

## Test plan
- Continuous frame:
  - Stimulus: seed 15'h2AAA, in_valid=1 throughout, FRAME_LEN=96.
  - Required: exactly one prbs_load, then 96 out_valid cycles whose out_bit matches the golden model; done in cycle start+98; frame_cnt=1; bit_cnt=96.
- Backpressure:
  - Stimulus: same frame with in_valid toggling 1,0,0,1 repeatedly.
  - Required: out_bit sequence identical to the continuous case; prbs_en low on every stall cycle; done after the 96th transfer only.
- Abort:
  - Stimulus: abort at bit_cnt=40 together with in_valid=1.
  - Required: no transfer in that cycle, state IDLE next cycle, no done, frame_cnt unchanged, bit_cnt=40; the next start reloads the seed and restarts the sequence from bit 0.
- Zero seed and ignored start:
  - Stimulus: start with seed_in=0; then start pulsed during RUN.
  - Required: seed_err pulse with busy staying 0; the start during RUN has no effect on the running frame.
- Reset mid-frame:
  - Stimulus: reset=0 for one cycle at bit_cnt=70.
  - Required: every output 0 on the following cycle, frame_cnt=0, no done.
- Wrap:
  - Stimulus: 256 back-to-back frames at minimum spacing.
  - Required: frame_cnt reads 0 after the 256th done; every frame shows a 3-cycle gap from done to the first transfer of the next frame.
